// File: rtl/crc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : crc_req_arbiter
// Description : Round-robin arbiter sharing the CRC sequencer request channel
//               among NUM_REQ requesters. Granted requests are tagged with the
//               requester index in req_id[15:16-IDX_W] and held in a one-entry
//               output slot. Responses are routed back by decoding that tag.
//               Per-requester outstanding counters limit in-flight commands.
//               Optional feature macro: CRC_ARB_PRIO_EN (requester 0 gets
//               strict priority; the others share round-robin).
// Revision    : 1.0 - initial release
// ============================================================================
module crc_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_W     = 128,
    parameter int MAX_OUTST = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [NUM_REQ*REQ_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_crc_req_valid,
    output logic [REQ_W-1:0]       o_crc_req_data,
    input  logic                   i_crc_req_ready,
    input  logic                   i_crc_done_valid,
    input  logic [23:0]            i_crc_done_data,
    output logic                   o_crc_done_ready,
    output logic [NUM_REQ-1:0]     o_rsp_valid,
    output logic [23:0]            o_rsp_data,
    input  logic [NUM_REQ-1:0]     i_rsp_ready,
    output logic [NUM_REQ*4-1:0]   o_outst_cnt,
    output logic                   o_err_unexp
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int TAG_LSB = 16 - IDX_W;

    localparam logic [3:0]       c_MAX_OUTST = 4'(MAX_OUTST);
    localparam logic [IDX_W:0]   c_NUM_REQ   = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_REQ - 1);

    // Output slot state encoding
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [IDX_W-1:0]       r_ptr;
    logic [NUM_REQ*4-1:0]   r_cnt;
    logic [REQ_W-1:0]       r_slot_data;
    logic                   r_err;

    logic                   w_arb_en;
    logic [NUM_REQ-1:0]     w_elig;
    logic                   w_grant_vld;
    logic [IDX_W-1:0]       w_grant_idx;
    logic [IDX_W:0]         w_sum;
    logic [IDX_W-1:0]       w_cand;
    logic                   w_ptr_upd;
    logic [IDX_W-1:0]       w_ptr_nxt;
    logic [REQ_W-1:0]       w_tagged;

    logic [IDX_W-1:0]       w_rsp_idx;
    logic                   w_rsp_hit;
    logic                   w_rsp_rdy_sel;
    logic                   w_rsp_xfer;

    // A requester may compete only while it is below its outstanding limit
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_elig
            assign w_elig[k] = i_req_valid[k] && (r_cnt[k*4 +: 4] < c_MAX_OUTST);
        end
    endgenerate

    // Pick the first eligible requester at or after the pointer (wrapping)
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_cand      = '0;
        if (w_arb_en) begin
`ifdef CRC_ARB_PRIO_EN
            if (w_elig[0]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = '0;
            end
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
                if (w_sum >= c_NUM_REQ) begin
                    w_sum = w_sum - c_NUM_REQ;
                end
                w_cand = w_sum[IDX_W-1:0];
                if (!w_grant_vld && w_elig[w_cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    // Pointer moves past the winner; a priority grant to requester 0 leaves it alone
    always_comb begin
        w_ptr_nxt = (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + 1'b1;
`ifdef CRC_ARB_PRIO_EN
        w_ptr_upd = w_grant_vld && (w_grant_idx != '0);
`else
        w_ptr_upd = w_grant_vld;
`endif
    end

    // Select the winner's word and overwrite the top id bits with its index
    always_comb begin
        w_tagged = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_idx == IDX_W'(k)) begin
                w_tagged = i_req_data[k*REQ_W +: REQ_W];
            end
        end
        w_tagged[15:TAG_LSB] = w_grant_idx;
    end

    // One-hot ready to the winning requester only
    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_vld && (w_grant_idx == IDX_W'(k))) begin
                o_req_ready[k] = 1'b1;
            end
        end
    end

    // Slot state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot next state: load on grant, drain on downstream accept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_grant_vld) begin
                    w_state_nxt = c_ST_FULL;
                end
            end
            c_ST_FULL: begin
                if (w_grant_vld) begin
                    w_state_nxt = c_ST_FULL;
                end else if (i_crc_req_ready) begin
                    w_state_nxt = c_ST_EMPTY;
                end
            end
            default: w_state_nxt = c_ST_EMPTY;
        endcase
    end

    // Slot outputs: arbitration runs only when the slot is free or draining
    always_comb begin
        o_crc_req_valid = (r_state == c_ST_FULL);
        w_arb_en        = !i_reset && ((r_state == c_ST_EMPTY) || i_crc_req_ready);
    end

    // Slot payload and round-robin pointer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slot_data <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_grant_vld) begin
                r_slot_data <= w_tagged;
            end
            if (w_ptr_upd) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign o_crc_req_data = r_slot_data;

    // Decode the response tag and find whether its owner has anything in flight
    assign w_rsp_idx = i_crc_done_data[15:TAG_LSB];

    always_comb begin
        w_rsp_hit     = 1'b0;
        w_rsp_rdy_sel = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_rsp_idx == IDX_W'(k)) begin
                w_rsp_hit     = (r_cnt[k*4 +: 4] != 4'd0);
                w_rsp_rdy_sel = i_rsp_ready[k];
            end
        end
    end

    // Route the response to its owner; unknown owners are swallowed
    always_comb begin
        o_rsp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_rsp_hit && i_crc_done_valid && (w_rsp_idx == IDX_W'(k))) begin
                o_rsp_valid[k] = 1'b1;
            end
        end
        o_crc_done_ready = w_rsp_hit ? w_rsp_rdy_sel : 1'b1;
        w_rsp_xfer       = i_crc_done_valid && w_rsp_hit && w_rsp_rdy_sel;
    end

    assign o_rsp_data = i_crc_done_data;

    // Outstanding counters: +1 on grant, -1 on routed response transfer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                case ({o_req_ready[k], w_rsp_xfer && (w_rsp_idx == IDX_W'(k))})
                    2'b10:   r_cnt[k*4 +: 4] <= r_cnt[k*4 +: 4] + 4'd1;
                    2'b01:   r_cnt[k*4 +: 4] <= r_cnt[k*4 +: 4] - 4'd1;
                    default: r_cnt[k*4 +: 4] <= r_cnt[k*4 +: 4];
                endcase
            end
        end
    end

    assign o_outst_cnt = r_cnt;

    // Sticky flag for a response nobody is waiting for
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (i_crc_done_valid && !w_rsp_hit) begin
            r_err <= 1'b1;
        end
    end

    assign o_err_unexp = r_err;

endmodule
`default_nettype wire

// File: tb/tb_crc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_req_arbiter
// Description : Self-checking bench for crc_req_arbiter (NUM_REQ=4,
//               REQ_W=128, MAX_OUTST=4) with a cycle model and directed tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_req_arbiter;

    localparam int N    = 4;
    localparam int W    = 128;
    localparam int MAXO = 4;
`ifdef CRC_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           crc_valid;
    logic [W-1:0]   crc_data;
    logic           crc_ready;
    logic           done_valid;
    logic [23:0]    done_data;
    logic           done_ready;
    logic [N-1:0]   rsp_valid;
    logic [23:0]    rsp_data;
    logic [N-1:0]   rsp_ready;
    logic [N*4-1:0] outst;
    logic           err;

    always #5 clk = ~clk;

    crc_req_arbiter #(.NUM_REQ(N), .REQ_W(W), .MAX_OUTST(MAXO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .o_crc_req_valid(crc_valid), .o_crc_req_data(crc_data), .i_crc_req_ready(crc_ready),
        .i_crc_done_valid(done_valid), .i_crc_done_data(done_data), .o_crc_done_ready(done_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .i_rsp_ready(rsp_ready),
        .o_outst_cnt(outst), .o_err_unexp(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_cnt [N];
    int           m_ptr;
    bit           m_slot_v;
    logic [W-1:0] m_slot_d;
    bit           m_err;
    bit           m_ok = 1'b0;

    function automatic int model_grant();
        if (rst || (m_slot_v && !crc_ready)) return -1;
        if (PRIO && req_valid[0] && m_cnt[0] < MAXO) return 0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req_valid[k] && m_cnt[k] < MAXO) return k;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] model_tag(input int k);
        logic [W-1:0] d;
        logic [1:0]   t;
        d = req_data[k*W +: W];
        t = 2'(k);
        d[15:14] = t;
        return d;
    endfunction

    always @(negedge clk) begin
        int           g;
        int           idx;
        bit           hit;
        logic [N-1:0] exp_rr;
        logic [N-1:0] exp_rv;
        logic [N*4-1:0] exp_cnt;
        g   = model_grant();
        idx = int'(done_data[15:14]);
        hit = (m_cnt[idx] > 0);
        if (m_ok) begin
            exp_rr = '0;
            if (g >= 0) exp_rr[g] = 1'b1;
            exp_rv = '0;
            if (hit && done_valid) exp_rv[idx] = 1'b1;
            for (int k = 0; k < N; k++) exp_cnt[k*4 +: 4] = 4'(m_cnt[k]);
            check("m_req_ready", req_ready, exp_rr);
            check("m_crc_valid", crc_valid, m_slot_v);
            check("m_crc_data", crc_data, m_slot_d);
            check("m_rsp_valid", rsp_valid, exp_rv);
            check("m_rsp_data", rsp_data, done_data);
            check("m_outst", outst, exp_cnt);
            check("m_err", err, m_err);
            if (done_valid) check("m_done_ready", done_ready, hit ? rsp_ready[idx] : 1'b1);
        end
        if (rst) begin
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
            m_ptr = 0; m_slot_v = 1'b0; m_slot_d = '0; m_err = 1'b0; m_ok = 1'b1;
        end else if (m_ok) begin
            if (g >= 0) begin
                m_slot_v = 1'b1;
                m_slot_d = model_tag(g);
                m_cnt[g]++;
                if (!(PRIO && g == 0)) m_ptr = (g + 1) % N;
            end else if (crc_ready) begin
                m_slot_v = 1'b0;
            end
            if (done_valid) begin
                if (hit) begin
                    if (rsp_ready[idx]) m_cnt[idx]--;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] saved;

    initial begin
        rst = 1'b1; req_valid = '0; crc_ready = 1'b0;
        done_valid = 1'b0; done_data = '0; rsp_ready = '0;
        for (int k = 0; k < N; k++)
            req_data[k*W +: W] = {32'hDEAD0000 + 32'(k), 64'h0123456789ABCDEF, 16'h5A5A, 16'hCABC};
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_crc_valid", crc_valid, 1'b0);
        check("rst_outst", outst, 16'h0000);
        check("rst_err", err, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 4'b0000);

`ifndef CRC_ARB_PRIO_EN
        // T1: all requesters valid, downstream always ready
        req_valid = 4'hF; crc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check("t1_grant", req_ready, 4'b0001 << (i % 4));
            step();
            check("t1_tag", crc_data[15:0], 16'h0ABC | 16'((i % 4) << 14));
        end
        check("t1_outst", outst, 16'h2222);
        req_valid = '0;
        step();
        check("t1_slot_empty", crc_valid, 1'b0);
        // drain all responses
        done_valid = 1'b1; rsp_ready = 4'hF;
        for (int k = 0; k < N; k++) begin
            for (int r = 0; r < 2; r++) begin
                done_data = {8'h40 + 8'(k), 2'(k), 14'h0ABC};
                #1 check("t1_rsp_route", rsp_valid, 4'b0001 << k);
                check("t1_done_ready", done_ready, 1'b1);
                step();
            end
        end
        done_valid = 1'b0;
        #1 check("t1_drained", outst, 16'h0000);

        // T2: requester 2 hits the outstanding limit
        req_valid = 4'b0100;
        repeat (4) step();
        check("t2_held", req_ready, 4'b0000);
        check("t2_cnt4", outst[11:8], 4'd4);
        done_valid = 1'b1; done_data = {8'h77, 16'h8005};
        #1 check("t2_rsp_valid", rsp_valid, 4'b0100);
        check("t2_done_ready", done_ready, 1'b1);
        check("t2_rsp_data", rsp_data, 24'h778005);
        step();
        done_valid = 1'b0;
        #1 check("t2_cnt3", outst[11:8], 4'd3);
        check("t2_resume", req_ready, 4'b0100);
        step();
        check("t2_cnt4b", outst[11:8], 4'd4);

        // T3: downstream stall with the slot full
        crc_ready = 1'b0; req_valid = 4'b1011;
        saved = crc_data;
        for (int i = 0; i < 5; i++) begin
            #1 check("t3_no_ready", req_ready, 4'b0000);
            check("t3_stable", crc_data, saved);
            check("t3_valid", crc_valid, 1'b1);
            step();
        end
        crc_ready = 1'b1;
        #1 check("t3_reload", req_ready, 4'b1000);
        step();
        check("t3_reload_tag", crc_data[15:14], 2'd3);
        req_valid = '0;
        step();

        // T4: response for a requester with nothing outstanding
        done_valid = 1'b1; done_data = {8'h11, 16'h4000}; rsp_ready = '0;
        #1 check("t4_done_ready", done_ready, 1'b1);
        check("t4_rsp_valid", rsp_valid, 4'b0000);
        check("t4_err_before", err, 1'b0);
        step();
        done_valid = 1'b0;
        check("t4_err_set", err, 1'b1);
        step(); step();
        check("t4_err_sticky", err, 1'b1);

        // T5: same-cycle grant and response for requester 3
        req_valid = 4'b1000; crc_ready = 1'b1;
        done_valid = 1'b1; done_data = {8'h33, 16'hC000}; rsp_ready = 4'b1000;
        #1 check("t5_grant", req_ready, 4'b1000);
        check("t5_rsp", rsp_valid, 4'b1000);
        step();
        done_valid = 1'b0; req_valid = '0; rsp_ready = '0;
        check("t5_cnt_same", outst[15:12], 4'd1);
`else
        // Priority: requester 0 wins every cycle while eligible
        req_valid = 4'hF; crc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("prio_grant0", req_ready, 4'b0001);
            step();
        end
        #1 check("prio_after_limit", req_ready, 4'b0010);
        step();
`endif

        // T6: reset in the middle of a burst
        req_valid = 4'hF; crc_ready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("t6_outst", outst, 16'h0000);
        check("t6_valid", crc_valid, 1'b0);
        check("t6_err", err, 1'b0);
        check("t6_req_ready", req_ready, 4'b0000);
        check("t6_data", crc_data, 128'h0);
        rst = 1'b0;
        #1 check("t6_regrant_p0", req_ready, 4'b0001);
        step();
        check("t6_tag0", crc_data[15:14], 2'd0);
        req_valid = '0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
